// File: rtl/sreg_pipe_pkg.sv
// Shared types and helpers for the SRL-based flow-controlled delay pipe.
package sreg_pipe_pkg;

    // Controller state: RUN accepts new words, DRAIN only empties the pipe.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ctrl_state_e;

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sreg_srl.sv
// Static multi-bit shift register with clock enable and no reset.
// Written so that synthesis maps it onto LUT shift registers (SRLs);
// SRL_STYLE_VAL is forwarded as the srl_style hint, "reg" drops the hint.
module sreg_srl #(
    parameter int WIDTH         = 4,
    parameter int DEPTH         = 8,
    parameter     SRL_STYLE_VAL = "srl"
) (
    input  logic             clk_i,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (SRL_STYLE_VAL == "reg") begin : g_reg
        logic [WIDTH-1:0] sr_q [DEPTH];

        // Shift one stage per enabled clock; no reset so it can stay in LUTs.
        always_ff @(posedge clk_i) begin
            if (ce_i) begin
                sr_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end

        assign q_o = sr_q[DEPTH-1];
    end else begin : g_srl
        (* srl_style = SRL_STYLE_VAL *) logic [WIDTH-1:0] sr_q [DEPTH];

        // Shift one stage per enabled clock; no reset so it can stay in LUTs.
        always_ff @(posedge clk_i) begin
            if (ce_i) begin
                sr_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end

        assign q_o = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/sreg_valid_track.sv
// Per-stage valid bits (resettable, shifted in lockstep with the data SRL)
// and an occupancy counter of valid words currently in the pipe.
module sreg_valid_track
    import sreg_pipe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       adv_i,
    input  logic                       acc_i,
    input  logic                       deq_i,
    output logic                       m_valid_o,
    output logic [occ_w(DEPTH)-1:0]    occ_o
);

    localparam int OW = occ_w(DEPTH);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_d;

    // Valid bits move with the data: a bubble enters whenever nothing is accepted.
    always_comb begin
        vld_d = vld_q;
        if (adv_i) begin
            vld_d = {vld_q[DEPTH-2:0], acc_i};
        end
    end

    // Occupancy: +1 on accept, -1 on delivery, unchanged when both happen.
    always_comb begin
        occ_d = occ_q;
        if (acc_i && !deq_i) begin
            occ_d = occ_q + OW'(1);
        end else if (!acc_i && deq_i) begin
            occ_d = occ_q - OW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    // The pipe holds at most one word per stage, so the count cannot pass DEPTH.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (occ_q <= OW'(DEPTH));
        end
    end

    assign m_valid_o = vld_q[DEPTH-1];
    assign occ_o     = occ_q;

endmodule

// File: rtl/sreg_pipe_ctrl.sv
// Flow-controlled fixed-latency pipe built on a static SRL delay line.
//
// Handshake: a word moves on either side only in a cycle where both valid
// and ready are high at the rising edge. valid never depends on ready;
// s_ready depends combinationally on m_ready (s_ready = adv while in RUN).
// The whole pipe advances together when the output slot is empty or being
// taken (adv = !m_valid | m_ready); otherwise it freezes and m_data holds.
module sreg_pipe_ctrl
    import sreg_pipe_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int DEPTH         = 8,      // must be >= 2
    parameter     SRL_STYLE_VAL = "srl"
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       busy,
    output logic [occ_w(DEPTH)-1:0]    occupancy,
    output logic                       state_dbg
);

    ctrl_state_e state_q;
    logic        flush_done_q;
    logic        adv;
    logic        acc;
    logic        deq;

    assign adv     = !m_valid | m_ready;
    assign s_ready = adv & (state_q == RUN);
    assign acc     = s_valid & s_ready;
    assign deq     = m_valid & m_ready;

    // Data path: bubbles still shift s_data in; their slots are masked by vld.
    sreg_srl #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .SRL_STYLE_VAL (SRL_STYLE_VAL)
    ) u_srl (
        .clk_i (clk),
        .ce_i  (adv),
        .d_i   (s_data),
        .q_o   (m_data)
    );

    sreg_valid_track #(
        .DEPTH (DEPTH)
    ) u_track (
        .clk_i     (clk),
        .rst_i     (rst),
        .adv_i     (adv),
        .acc_i     (acc),
        .deq_i     (deq),
        .m_valid_o (m_valid),
        .occ_o     (occupancy)
    );

    // Drain controller: stop accepting on flush, return to RUN once empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((occupancy == '0) && !deq) begin
                        state_q      <= RUN;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign flush_done = flush_done_q;
    assign busy       = (occupancy != '0) || (state_q == DRAIN);
    assign state_dbg  = (state_q == DRAIN);

endmodule

// File: tb/tb_sreg_pipe_ctrl.sv
// Bench for sreg_pipe_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a slot-queue model of the pipe.
module tb_sreg_pipe_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int OW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             flush;
    logic             flush_done;
    logic             busy;
    logic [OW-1:0]    occupancy;
    logic             state_dbg;

    sreg_pipe_ctrl #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .SRL_STYLE_VAL ("srl")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy),
        .occupancy  (occupancy),
        .state_dbg  (state_dbg)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the pipe is a fixed-length line of DEPTH slots, each
    // either a word or a bubble; front slot is what the consumer sees.
    bit               slot_q[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               mdl_drain;
    bit               mdl_fd;
    bit               known;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mdl_occ();
        int n = 0;
        foreach (slot_q[i]) if (slot_q[i]) n++;
        return n;
    endfunction

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic cycle(input bit r, input bit sv, input logic [WIDTH-1:0] sd,
                         input bit mr, input bit fl);
        bit mv;
        bit adv;
        bit acc;
        bit deq;
        int occ;
        @(negedge clk);
        rst     = r;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        #1;
        if (known) begin
            mv  = slot_q[0];
            occ = mdl_occ();
            check_eq("m_valid", 32'(m_valid), 32'(mv));
            if (mv && exp_q.size() != 0) check_eq("m_data", 32'(m_data), 32'(exp_q[0]));
            check_eq("s_ready", 32'(s_ready), 32'((!mv || mr) && !mdl_drain));
            check_eq("occupancy", 32'(occupancy), 32'(occ));
            check_eq("busy", 32'(busy), 32'(occ != 0 || mdl_drain));
            check_eq("flush_done", 32'(flush_done), 32'(mdl_fd));
            check_eq("state", 32'(state_dbg), 32'(mdl_drain));
        end
        if (r) begin
            slot_q = {};
            for (int i = 0; i < DEPTH; i++) slot_q.push_back(1'b0);
            exp_q.delete();
            mdl_drain = 1'b0;
            mdl_fd    = 1'b0;
            known     = 1'b1;
        end else if (known) begin
            mv  = slot_q[0];
            adv = !mv || mr;
            acc = sv && adv && !mdl_drain;
            deq = mv && mr;
            occ = mdl_occ();
            mdl_fd = mdl_drain && occ == 0 && !deq;
            if (!mdl_drain) mdl_drain = fl;
            else if (occ == 0 && !deq) mdl_drain = 1'b0;
            if (deq) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(sd);
            if (adv) begin
                void'(slot_q.pop_front());
                slot_q.push_back(acc);
            end
        end
    endtask

    task automatic idle(input int n, input bit mr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, WIDTH'($urandom), mr, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        known     = 1'b0;
        mdl_drain = 1'b0;
        mdl_fd    = 1'b0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; flush = 1'b0;

        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Streaming 0x1..0xA at full rate.
        for (int i = 1; i <= 10; i++) cycle(1'b0, 1'b1, WIDTH'(i), 1'b1, 1'b0);
        idle(12, 1'b1);

        // Bubbles between words.
        cycle(1'b0, 1'b1, 4'h3, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, WIDTH'($urandom), 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 4'h5, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, WIDTH'($urandom), 1'b1, 1'b0);
        idle(12, 1'b1);

        // Backpressure: fill, hold 5 cycles, release.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, WIDTH'(i + 6), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, WIDTH'(i + 1), 1'b1, 1'b0);
        idle(12, 1'b1);

        // Flush with three words in flight; producer keeps offering.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, WIDTH'(i + 10), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b1, 1'b0);

        // Flush with an empty pipe.
        idle(2, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Flush during a stall, then a second flush while draining.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle(4, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(12, 1'b1);

        // Reset mid-stream with five words in flight.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, WIDTH'(i + 2), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 4'h9, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 4'hC, 1'b1, 1'b0);
        idle(10, 1'b1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  WIDTH'($urandom),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 29) == 0));
        end
        idle(12, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
